// File: rtl/mmr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmr_arbiter_pkg
// Purpose  : Shared state encodings, requester indices and a grant helper for
//            the two-requester MMR bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mmr_arbiter_pkg;

    typedef logic [1:0] state_t;

    // FSM state encodings
    localparam state_t c_IDLE   = 2'd0;
    localparam state_t c_ACCESS = 2'd1;
    localparam state_t c_ACK    = 2'd2;

    // Requester indices into req/grant vectors
    localparam logic c_REQ_A = 1'b0;
    localparam logic c_REQ_B = 1'b1;

    // One-hot grant vector for a requester index
    function automatic logic [1:0] onehot_grant(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mmr_arbiter_if
// Purpose  : Requester handshakes (A and B) plus the shared bus control lines.
//            The shared tri-state data bus is kept as a plain port on the
//            arbiter so its resolution stays at module level.
// Revision : 1.0 - initial release
// ============================================================================
interface mmr_arbiter_if #(
    parameter int ABITS = 32,
    parameter int DBITS = 32
);
    logic             a_req;
    logic             a_rw;
    logic [ABITS-1:0] a_addr;
    logic [DBITS-1:0] a_wdata;
    logic             a_ack;
    logic [DBITS-1:0] a_rdata;

    logic             b_req;
    logic             b_rw;
    logic [ABITS-1:0] b_addr;
    logic [DBITS-1:0] b_wdata;
    logic             b_ack;
    logic [DBITS-1:0] b_rdata;

    logic             bus_enable;
    logic             bus_rw;
    logic [ABITS-1:0] bus_addr;
    logic             busy;

    // Arbiter view
    modport slave (
        input  a_req, a_rw, a_addr, a_wdata,
        input  b_req, b_rw, b_addr, b_wdata,
        output a_ack, a_rdata, b_ack, b_rdata,
        output bus_enable, bus_rw, bus_addr, busy
    );

    // Requester / bus-observer view
    modport master (
        output a_req, a_rw, a_addr, a_wdata,
        output b_req, b_rw, b_addr, b_wdata,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  bus_enable, bus_rw, bus_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/mmr_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mmr_arb_pick
// Purpose  : Combinational winner selection between requesters A and B.
//            MMR_ARB_ROUND_ROBIN_EN defined  : ties go to the pointer's side.
//            MMR_ARB_ROUND_ROBIN_EN undefined: A always wins ties; pointer
//                                              is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mmr_arb_pick
    import mmr_arbiter_pkg::*;
(
    input  wire logic [1:0] req,
    input  wire logic       pointer,
    output logic [1:0]      grant
);

`ifdef MMR_ARB_ROUND_ROBIN_EN
    // Round-robin: the pointer breaks ties, a lone request always wins
    always_comb begin
        grant = 2'b00;
        if (req[c_REQ_A] && req[c_REQ_B]) begin
            grant = onehot_grant(pointer);
        end else if (req[c_REQ_A]) begin
            grant = onehot_grant(c_REQ_A);
        end else if (req[c_REQ_B]) begin
            grant = onehot_grant(c_REQ_B);
        end
    end
`else
    // Fixed priority: the tie-break pointer has no effect and is trimmed
    logic w_unused_pointer;
    assign w_unused_pointer = pointer;

    // Fixed priority: A over B
    always_comb begin
        grant = 2'b00;
        if (req[c_REQ_A]) begin
            grant = onehot_grant(c_REQ_A);
        end else if (req[c_REQ_B]) begin
            grant = onehot_grant(c_REQ_B);
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mmr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mmr_arbiter
// Purpose  : Serialises two req/ack requesters onto one MMR bus.
//            IDLE -> ACCESS (1 cycle, bus strobe) -> ACK (1 cycle, ack pulse).
//            Drives the tri-state data bus only during a write ACCESS cycle.
// Options  : MMR_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking
//            (default: fixed priority, A wins).
// Revision : 1.0 - initial release
// ============================================================================
module mmr_arbiter
    import mmr_arbiter_pkg::*;
#(
    parameter int ABITS = 32,
    parameter int DBITS = 32
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    mmr_arbiter_if.slave          bus_if,
    inout  wire       [DBITS-1:0] bus_data
);

    state_t           r_state;
    state_t           w_next_state;

    logic             r_win;
    logic             r_rw;
    logic [ABITS-1:0] r_addr;
    logic [DBITS-1:0] r_wdata;
    logic [DBITS-1:0] r_a_rdata;
    logic [DBITS-1:0] r_b_rdata;
    logic             r_pointer;

    logic [1:0]       w_req;
    logic [1:0]       w_grant;
    logic             w_take;

    logic             w_bus_enable;
    logic             w_bus_rw;
    logic             w_drive;
    logic             w_a_ack;
    logic             w_b_ack;
    logic             w_busy;

    assign w_req  = {bus_if.b_req, bus_if.a_req};
    assign w_take = (r_state == c_IDLE) && (|w_grant);

    mmr_arb_pick u_pick (
        .req     (w_req),
        .pointer (r_pointer),
        .grant   (w_grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: requests are only looked at in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (|w_req) w_next_state = c_ACCESS;
            c_ACCESS: w_next_state = c_ACK;
            c_ACK:    w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // Latch the winner's transaction and move the tie-break pointer off it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_win     <= c_REQ_A;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_pointer <= c_REQ_A;
        end else if (w_take) begin
            if (w_grant[c_REQ_B]) begin
                r_win   <= c_REQ_B;
                r_rw    <= bus_if.b_rw;
                r_addr  <= bus_if.b_addr;
                r_wdata <= bus_if.b_wdata;
            end else begin
                r_win   <= c_REQ_A;
                r_rw    <= bus_if.a_rw;
                r_addr  <= bus_if.a_addr;
                r_wdata <= bus_if.a_wdata;
            end
            r_pointer <= w_grant[c_REQ_A];
        end
    end

    // Capture read data into the winner's return register at the end of ACCESS;
    // writes leave the previous read value in place
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else if ((r_state == c_ACCESS) && !r_rw) begin
            if (r_win == c_REQ_B) begin
                r_b_rdata <= bus_data;
            end else begin
                r_a_rdata <= bus_data;
            end
        end
    end

    // Output decode, purely from registered state
    always_comb begin
        w_bus_enable = 1'b0;
        w_bus_rw     = 1'b0;
        w_drive      = 1'b0;
        w_a_ack      = 1'b0;
        w_b_ack      = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            c_ACCESS: begin
                w_bus_enable = 1'b1;
                w_bus_rw     = r_rw;
                w_drive      = r_rw;
                w_busy       = 1'b1;
            end
            c_ACK: begin
                w_a_ack = (r_win == c_REQ_A);
                w_b_ack = (r_win == c_REQ_B);
                w_busy  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus_if.bus_enable = w_bus_enable;
    assign bus_if.bus_rw     = w_bus_rw;
    assign bus_if.bus_addr   = r_addr;
    assign bus_if.busy       = w_busy;
    assign bus_if.a_ack      = w_a_ack;
    assign bus_if.b_ack      = w_b_ack;
    assign bus_if.a_rdata    = r_a_rdata;
    assign bus_if.b_rdata    = r_b_rdata;

    assign bus_data = w_drive ? r_wdata : {DBITS{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mmr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmr_arbiter
// Purpose  : Scoreboard bench for mmr_arbiter with a small register-bank
//            target model on the shared bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmr_arbiter;

    localparam logic [31:0] c_PARK = 32'hA5A5_5A5A;

    typedef struct packed {
        logic        who;
        logic [31:0] rdata;
    } ack_t;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset_n;
    wire  [31:0] bus_data;

    mmr_arbiter_if #(.ABITS(32), .DBITS(32)) bif ();

    mmr_arbiter #(.ABITS(32), .DBITS(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus_if   (bif),
        .bus_data (bus_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ack_t ack_q[$];
    bus_t bus_q[$];
    logic [31:0] last_rd [2];

    // Target register bank: 64 words, address bits [7:2]
    logic [31:0] mem [64];
    logic        mem_init = 1'b0;
    logic [31:0] tb_val;

    always_comb begin
        tb_val = c_PARK;
        if (bif.bus_enable && !bif.bus_rw) tb_val = mem[bif.bus_addr[7:2]];
    end

    assign bus_data = (bif.bus_enable && bif.bus_rw) ? 32'bz : tb_val;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0C0D_0000 | i;
            mem_init <= 1'b1;
        end else if (bif.bus_enable && bif.bus_rw) begin
            mem[bif.bus_addr[7:2]] <= bus_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a bus access or ack
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        ack_t ea;
        bus_t eb;
        if (bif.a_ack && bif.b_ack) check("both_acks", 2'b11, 2'b01);
        if (bif.a_ack || bif.b_ack) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", {bif.b_ack, bif.a_ack}, 2'b00);
            end else begin
                ea = ack_q.pop_front();
                check("ack_who", {bif.b_ack, bif.a_ack}, ea.who ? 2'b10 : 2'b01);
                check("ack_rdata", ea.who ? bif.b_rdata : bif.a_rdata, ea.rdata);
            end
        end
        if (bif.bus_enable) begin
            check("bus_enable_gap", prev_en, 1'b0);
            if (bus_q.size() == 0) begin
                check("unexpected_access", bif.bus_addr, 32'hFFFF_FFFF);
            end else begin
                eb = bus_q.pop_front();
                check("bus_rw", bif.bus_rw, eb.rw);
                check("bus_addr", bif.bus_addr, eb.addr);
                if (eb.rw) check("bus_wdata", bus_data, eb.wdata);
                else       check("bus_released_rd", bus_data, mem[eb.addr[7:2]]);
            end
        end else begin
            check("bus_released", bus_data, c_PARK);
        end
        prev_en <= bif.bus_enable;
    end

    // Queue one uncontended transfer and run it to its ack; called at a negedge
    task automatic xfer(input logic who, input logic rw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
        int lat;
        bus_q.push_back('{rw: rw, addr: addr, wdata: wdata});
        ack_q.push_back('{who: who, rdata: rw ? last_rd[who] : exp_rd});
        if (!rw) last_rd[who] = exp_rd;
        if (who) begin
            bif.b_req = 1'b1; bif.b_rw = rw; bif.b_addr = addr; bif.b_wdata = wdata;
        end else begin
            bif.a_req = 1'b1; bif.a_rw = rw; bif.a_addr = addr; bif.a_wdata = wdata;
        end
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                check("lat_enable_n1", bif.bus_enable, 1'b1);
                check("lat_busy_n1", bif.busy, 1'b1);
            end
            if (who ? bif.b_ack : bif.a_ack) break;
        end
        check("ack_latency", lat, 2);
        check("enable_in_ack", bif.bus_enable, 1'b0);
        bif.a_req = 1'b0;
        bif.b_req = 1'b0;
    endtask

    // Stimulus
    initial begin
        int acks;
        int last_ack_cyc;
        int n;
        reset_n   = 1'b0;
        bif.a_req = 1'b0; bif.a_rw = 1'b0; bif.a_addr = '0; bif.a_wdata = '0;
        bif.b_req = 1'b0; bif.b_rw = 1'b0; bif.b_addr = '0; bif.b_wdata = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_bus_enable", bif.bus_enable, 1'b0);
        check("rst_bus_rw", bif.bus_rw, 1'b0);
        check("rst_bus_addr", bif.bus_addr, 32'h0);
        check("rst_acks", {bif.a_ack, bif.b_ack}, 2'b00);
        check("rst_rdata", {bif.a_rdata, bif.b_rdata}, 64'h0);
        check("rst_busy", bif.busy, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // A write then read back
        xfer(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        xfer(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk);

        // Back-to-back: a_req held over three reads
        bus_q.push_back('{rw: 1'b0, addr: 32'h100, wdata: 32'h0});
        bus_q.push_back('{rw: 1'b0, addr: 32'h108, wdata: 32'h0});
        bus_q.push_back('{rw: 1'b0, addr: 32'h10C, wdata: 32'h0});
        ack_q.push_back('{who: 1'b0, rdata: 32'hDEAD_BEEF});
        ack_q.push_back('{who: 1'b0, rdata: 32'h0C0D_0002});
        ack_q.push_back('{who: 1'b0, rdata: 32'h0C0D_0003});
        last_rd[0] = 32'h0C0D_0003;
        bif.a_req = 1'b1; bif.a_rw = 1'b0; bif.a_addr = 32'h100;
        acks = 0; n = 0; last_ack_cyc = 0;
        while (acks < 3 && n < 30) begin
            @(negedge clk);
            n++;
            if (bif.a_ack) begin
                if (acks > 0) check("b2b_ack_spacing", cyc - last_ack_cyc, 3);
                last_ack_cyc = cyc;
                acks++;
                bif.a_addr = (acks == 1) ? 32'h108 : 32'h10C;
                if (acks == 3) bif.a_req = 1'b0;
            end
        end
        check("b2b_ack_count", acks, 3);
        bif.a_req = 1'b0;
        @(negedge clk);

        // Reset during the ACCESS cycle of a B write
        bus_q.push_back('{rw: 1'b1, addr: 32'h104, wdata: 32'h55});
        bif.b_req = 1'b1; bif.b_rw = 1'b1; bif.b_addr = 32'h104; bif.b_wdata = 32'h55;
        @(negedge clk);
        check("midrst_in_access", bif.bus_enable, 1'b1);
        reset_n   = 1'b0;
        bif.b_req = 1'b0;
        @(negedge clk);
        check("midrst_no_back", bif.b_ack, 1'b0);
        check("midrst_idle_busy", bif.busy, 1'b0);
        check("midrst_idle_en", bif.bus_enable, 1'b0);
        check("midrst_a_rdata", bif.a_rdata, 32'h0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_still_no_back", bif.b_ack, 1'b0);
        xfer(1'b1, 1'b0, 32'h104, 32'h0, 32'h0000_0055);
        @(negedge clk);

        // Contention: both held for four transactions
`ifdef MMR_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) begin
            bus_q.push_back('{rw: 1'b0, addr: (i % 2 == 0) ? 32'h110 : 32'h120, wdata: 32'h0});
            ack_q.push_back('{who: (i % 2 == 1), rdata: (i % 2 == 0) ? 32'h0C0D_0004 : 32'h0C0D_0008});
        end
        last_rd[0] = 32'h0C0D_0004;
        last_rd[1] = 32'h0C0D_0008;
`else
        for (int i = 0; i < 4; i++) begin
            bus_q.push_back('{rw: 1'b0, addr: 32'h110, wdata: 32'h0});
            ack_q.push_back('{who: 1'b0, rdata: 32'h0C0D_0004});
        end
        last_rd[0] = 32'h0C0D_0004;
`endif
        bif.a_req = 1'b1; bif.a_rw = 1'b0; bif.a_addr = 32'h110;
        bif.b_req = 1'b1; bif.b_rw = 1'b0; bif.b_addr = 32'h120;
        acks = 0; n = 0;
        while (acks < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (bif.a_ack || bif.b_ack) acks++;
            if (acks == 4) begin
                bif.a_req = 1'b0;
                bif.b_req = 1'b0;
            end
        end
        check("contention_acks", acks, 4);
        bif.a_req = 1'b0;
        bif.b_req = 1'b0;
        @(negedge clk);

        // Idle: nothing moves for 20 cycles
        repeat (20) begin
            @(negedge clk);
            check("idle_outputs", {bif.bus_enable, bif.a_ack, bif.b_ack, bif.busy}, 4'b0000);
        end

        check("ack_q_drained", ack_q.size(), 0);
        check("bus_q_drained", bus_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
